// File: rtl/ovl_win_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ovl_win_sched                                                 |
// | Purpose  : Round-robin time-sharing of one window-change checker among   |
// |            several requesters, with per-requester sticky fire flags.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ovl_win_sched #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0] win_len,
    input  logic [NUM_REQ*WIDTH-1:0]     test_bus,
    input  logic [2:0]                   chk_fire,
    input  logic [NUM_REQ-1:0]           err_clr,
    output logic                         start_event,
    output logic                         end_event,
    output logic [WIDTH-1:0]             test_expr,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         busy,
    output logic [NUM_REQ-1:0]           done,
    output logic [NUM_REQ-1:0]           err_vec
);

    localparam int c_SLOTS = 2**PTR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_OPEN  = 2'd2,
        S_CLOSE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PTR_WIDTH-1:0] r_owner;
    logic [PTR_WIDTH-1:0] w_owner_nxt;
    logic [PTR_WIDTH-1:0] r_ptr;
    logic [PTR_WIDTH-1:0] w_ptr_nxt;
    logic [PTR_WIDTH-1:0] w_sel;
    logic [PTR_WIDTH-1:0] w_idx;
    logic                 w_found;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] w_len_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 r_post;
    logic [NUM_REQ-1:0]   r_err;
    logic [NUM_REQ-1:0]   w_err_set;
    logic [NUM_REQ-1:0]   w_owner_hot;
    logic [c_SLOTS-1:0]   w_req_slot;
    logic [CNT_WIDTH-1:0] w_len_slot [c_SLOTS];
    logic [WIDTH-1:0]     w_bus_slot [c_SLOTS];
    logic                 w_unused_fire;

    // Only the assertion bit is attributed; x-check and cover fires are dropped.
    assign w_unused_fire = ^chk_fire[2:1];

    // Pad the per-requester buses out to a power-of-two slot count so the
    // pointer arithmetic wraps naturally; padding slots never request.
    generate
        for (genvar gi = 0; gi < c_SLOTS; gi++) begin : g_slot
            if (gi < NUM_REQ) begin : g_used
                assign w_req_slot[gi] = req[gi];
                assign w_len_slot[gi] = win_len[gi*CNT_WIDTH +: CNT_WIDTH];
                assign w_bus_slot[gi] = test_bus[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign w_req_slot[gi] = 1'b0;
                assign w_len_slot[gi] = '0;
                assign w_bus_slot[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < c_SLOTS; k++) begin
            w_idx = r_ptr + PTR_WIDTH'(k);
            if (!w_found && w_req_slot[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    always_comb begin
        w_owner_hot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_owner_hot[i] = (r_owner == PTR_WIDTH'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        start_event = 1'b0;
        end_event   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_found) begin
                    w_owner_nxt = w_sel;
                    w_len_nxt   = (w_len_slot[w_sel] == '0) ? CNT_WIDTH'(1)
                                                            : w_len_slot[w_sel];
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                start_event = 1'b1;
                busy        = 1'b1;
                w_cnt_nxt   = r_len - CNT_WIDTH'(1);
                w_state_nxt = (r_len > CNT_WIDTH'(1)) ? S_OPEN : S_CLOSE;
            end
            S_OPEN: begin
                busy      = 1'b1;
                w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
                if (r_cnt == CNT_WIDTH'(1)) begin
                    w_state_nxt = S_CLOSE;
                end
            end
            S_CLOSE: begin
                busy        = 1'b1;
                end_event   = 1'b1;
                w_ptr_nxt   = (r_owner == PTR_WIDTH'(NUM_REQ-1)) ? '0
                                                                 : r_owner + PTR_WIDTH'(1);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // The checker reports one cycle late, so the cycle after CLOSE still
    // belongs to the window that just ended.
    assign w_err_set = (chk_fire[0] && (busy || r_post)) ? w_owner_hot : '0;

    assign grant     = busy ? w_owner_hot : '0;
    assign done      = end_event ? w_owner_hot : '0;
    assign err_vec   = r_err;
    assign test_expr = w_bus_slot[r_owner];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_post  <= 1'b0;
            r_err   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_post  <= (r_state == S_CLOSE);
            r_err   <= (r_err & ~err_clr) | w_err_set;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ovl_win_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ovl_win_sched                                              |
// | Purpose  : Self-checking bench for ovl_win_sched against a window model.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ovl_win_sched;

    localparam int N  = 4;
    localparam int W  = 1;
    localparam int CW = 4;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [N-1:0]    req;
    logic [N*CW-1:0] win_len;
    logic [N*W-1:0]  test_bus;
    logic [2:0]      chk_fire;
    logic [N-1:0]    err_clr;
    logic            start_event;
    logic            end_event;
    logic [W-1:0]    test_expr;
    logic [N-1:0]    grant;
    logic            busy;
    logic [N-1:0]    done;
    logic [N-1:0]    err_vec;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: a window is described by owner, start cycle and end cycle.
    int           cyc;
    bit           m_has;
    int           m_start;
    int           m_end;
    int           m_owner;
    int           m_ptr;
    logic [N-1:0] m_err;

    always #5 clk = ~clk;

    ovl_win_sched #(
        .NUM_REQ  (N),
        .WIDTH    (W),
        .CNT_WIDTH(CW),
        .PTR_WIDTH(PW)
    ) u_dut (
        .clock      (clk),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .win_len    (win_len),
        .test_bus   (test_bus),
        .chk_fire   (chk_fire),
        .err_clr    (err_clr),
        .start_event(start_event),
        .end_event  (end_event),
        .test_expr  (test_expr),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .err_vec    (err_vec)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic rst_i, input logic en_i, input logic [N-1:0] req_i,
                        input logic [N*CW-1:0] len_i, input logic [2:0] fire_i,
                        input logic [N-1:0] clr_i);
        bit           in_win;
        bit           post;
        bit           found;
        int           sel;
        int           len;
        logic [N-1:0] hot;
        logic [N-1:0] setv;
        @(posedge clk);
        #1;
        reset    = rst_i;
        enable   = en_i;
        req      = req_i;
        win_len  = len_i;
        test_bus = (N*W)'($urandom);
        chk_fire = fire_i;
        err_clr  = clr_i;
        @(negedge clk);

        in_win = m_has && (cyc >= m_start) && (cyc <= m_end);
        post   = m_has && (cyc == m_end + 1);
        hot    = N'(1) << m_owner;
        check_eq("start_event", start_event, in_win && cyc == m_start);
        check_eq("end_event", end_event, in_win && cyc == m_end);
        check_eq("busy", busy, in_win);
        check_eq("grant", grant, in_win ? hot : '0);
        check_eq("done", done, (in_win && cyc == m_end) ? hot : '0);
        check_eq("test_expr", test_expr, test_bus[m_owner*W +: W]);
        check_eq("err_vec", err_vec, m_err);

        if (rst_i) begin
            m_has   = 1'b0;
            m_owner = 0;
            m_ptr   = 0;
            m_err   = '0;
        end else begin
            setv  = (fire_i[0] && (in_win || post)) ? hot : '0;
            m_err = (m_err & ~clr_i) | setv;
            if (in_win && cyc == m_end) m_ptr = (m_owner + 1) % N;
            if (!in_win && en_i && req_i != '0) begin
                found = 1'b0;
                sel   = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && req_i[(m_ptr + k) % N]) begin
                        found = 1'b1;
                        sel   = (m_ptr + k) % N;
                    end
                end
                len     = int'(len_i[sel*CW +: CW]);
                if (len == 0) len = 1;
                m_owner = sel;
                m_has   = 1'b1;
                m_start = cyc + 1;
                m_end   = cyc + 1 + len;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, '0, 3'b000, '0);
        step(1'b1, 1'b0, '0, '0, 3'b000, '0);
    endtask

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        req      = '0;
        win_len  = '0;
        test_bus = '0;
        chk_fire = '0;
        err_clr  = '0;
        cyc      = 0;
        m_has    = 1'b0;
        m_start  = 0;
        m_end    = 0;
        m_owner  = 0;
        m_ptr    = 0;
        m_err    = '0;
        repeat (2) @(posedge clk);

        // Single requester 1, length 3.
        do_reset();
        step(1'b0, 1'b1, 4'b0010, 16'h0030, 3'b000, '0);
        step(1'b0, 1'b1, 4'b0010, 16'h0030, 3'b000, '0);
        check_eq("tp1_grant", grant, 4'b0010);
        repeat (6) step(1'b0, 1'b1, 4'b0010, 16'h0030, 3'b000, '0);

        // Requesters 0 and 3 alternate, length 2 each.
        do_reset();
        repeat (18) step(1'b0, 1'b1, 4'b1001, 16'h2222, 3'b000, '0);

        // Zero length behaves as a one-cycle window.
        do_reset();
        repeat (6) step(1'b0, 1'b1, 4'b0100, 16'h0000, 3'b000, '0);

        // Fire attribution to owner 2 and clear.
        do_reset();
        repeat (6) step(1'b0, 1'b1, 4'b0100, 16'h0400, 3'b000, '0);
        step(1'b0, 1'b1, 4'b0000, 16'h0400, 3'b001, '0);
        step(1'b0, 1'b1, 4'b0000, 16'h0400, 3'b001, '0);
        check_eq("tp4_err_set", err_vec, 4'b0100);
        step(1'b0, 1'b1, 4'b0000, 16'h0400, 3'b000, 4'b0100);
        check_eq("tp4_err_hold", err_vec, 4'b0100);
        step(1'b0, 1'b1, 4'b0000, 16'h0400, 3'b000, '0);
        check_eq("tp4_err_clr", err_vec, 4'b0000);

        // Reset asserted while a window is open.
        do_reset();
        repeat (3) step(1'b0, 1'b1, 4'b0001, 16'h0005, 3'b000, '0);
        step(1'b1, 1'b1, 4'b0001, 16'h0005, 3'b000, '0);
        step(1'b0, 1'b0, 4'b0000, 16'h0005, 3'b000, '0);
        check_eq("tp5_busy", busy, 1'b0);
        repeat (6) step(1'b0, 1'b0, 4'b0000, 16'h0005, 3'b000, '0);

        // Enable gating, then enable dropped mid-window.
        do_reset();
        repeat (5) step(1'b0, 1'b0, 4'b1111, 16'h3333, 3'b000, '0);
        step(1'b0, 1'b1, 4'b1111, 16'h3333, 3'b000, '0);
        repeat (8) step(1'b0, 1'b0, 4'b1111, 16'h3333, 3'b000, '0);

        // Randomised traffic.
        do_reset();
        for (int t = 0; t < 2000; t++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 9) < 8),
                 N'($urandom),
                 (N*CW)'($urandom),
                 3'($urandom_range(0, 9) < 3 ? $urandom : 0),
                 ($urandom_range(0, 9) == 0) ? N'($urandom) : '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
